// File: rtl/uart_rx_ext_pkg.sv
// Shared types and helpers for the extended UART receiver: FSM encoding,
// data-width decoding and parity generation.
package uart_rx_ext_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BREAK_WAIT
    } rx_state_t;

    typedef struct packed {
        logic parity;
        logic frame;
        logic overrun;
        logic brk;
    } rx_err_t;

    localparam int         MIN_DATA_BITS = 5;
    localparam logic [2:0] BITS_CFG_MAX  = 3'd4;

    // Out-of-range encodings, and 9 bits on an 8-bit build, fall back to 8 bits.
    function automatic logic [3:0] data_bits(input logic [2:0] cfg, input int max_bits);
        logic [3:0] n;
        if (cfg > BITS_CFG_MAX) n = 4'd8;
        else                    n = 4'(cfg) + 4'(MIN_DATA_BITS);
        if (n > 4'(max_bits))   n = 4'(max_bits);
        return n;
    endfunction

    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter 0..div_i producing the three majority-vote strobes
// around the bit centre and an end-of-bit tick.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 restart_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 smp_early_o,
    output logic                 smp_mid_o,
    output logic                 smp_late_o,
    output logic                 bit_end_o
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] mid;

    assign mid = div_i >> 1;

    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i) cnt <= '0;
        else if (en_i)          cnt <= (cnt == div_i) ? '0 : cnt + ONE;
    end

    assign smp_early_o = en_i && (cnt == mid - ONE);
    assign smp_mid_o   = en_i && (cnt == mid);
    assign smp_late_o  = en_i && (cnt == mid + ONE);
    assign bit_end_o   = en_i && (cnt == div_i);

endmodule

// File: rtl/uart_rx_ext.sv
// Extended UART receiver: configurable framing, 3-sample majority vote,
// break detection, sticky error flags and a one-entry holding register.
module uart_rx_ext
    import uart_rx_ext_pkg::*;
#(
    parameter int DIV_WIDTH     = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_i,
    input  logic                     cfg_en_i,
    input  logic [DIV_WIDTH-1:0]     cfg_div_i,
    input  logic [2:0]               cfg_bits_i,
    input  logic                     cfg_parity_en_i,
    input  logic                     cfg_parity_odd_i,
    input  logic                     cfg_stop2_i,
    input  logic                     err_clr_i,
    output logic                     busy_o,
    output logic [MAX_DATA_BITS-1:0] rx_data_o,
    output logic                     rx_valid_o,
    input  logic                     rx_ready_i,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     overrun_o,
    output logic                     break_o
);

    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     rx_s, rx_prev;
    rx_state_t                state_q;
    logic [3:0]               bit_idx, nbits, shamt;
    logic [MAX_DATA_BITS-1:0] data_sr;
    logic [8:0]               data_ext;
    logic                     par_bit, par_exp;
    logic                     samp_e, samp_m, vote;
    logic                     smp_early, smp_mid, smp_late, bit_end;
    logic                     start_det, cnt_en, last_bit, accept, done, is_break;
    rx_err_t                  err_set, err_q;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i || !cfg_en_i) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_prev <= rx_s;
        end
    end

    assign start_det = (state_q == ST_IDLE) && rx_prev && !rx_s;
    assign cnt_en    = (state_q != ST_IDLE) && (state_q != ST_BREAK_WAIT);

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (cnt_en),
        .restart_i   (start_det),
        .div_i       (cfg_div_i),
        .smp_early_o (smp_early),
        .smp_mid_o   (smp_mid),
        .smp_late_o  (smp_late),
        .bit_end_o   (bit_end)
    );

    // Data shifts in from the MSB end; right-align by the unused width on delivery.
    assign nbits    = data_bits(cfg_bits_i, MAX_DATA_BITS);
    assign shamt    = 4'(MAX_DATA_BITS) - nbits;
    assign last_bit = (bit_idx == nbits - 4'd1);
    assign vote     = (samp_e & samp_m) | (samp_e & rx_s) | (samp_m & rx_s);
    assign par_exp  = parity_bit(data_ext, cfg_parity_odd_i);
    assign accept   = !rx_valid_o || rx_ready_i;
    assign is_break = (data_ext == '0) && (!cfg_parity_en_i || !par_bit);

    always_comb begin
        data_ext = '0;
        data_ext[MAX_DATA_BITS-1:0] = data_sr;
    end

    always_comb begin
        done    = 1'b0;
        err_set = '0;
        if (smp_late && cfg_en_i) begin
            unique case (state_q)
                ST_STOP1: begin
                    if (!vote) begin
                        err_set.frame = 1'b1;
                        err_set.brk   = is_break;
                        done          = !is_break;
                    end else begin
                        done = !cfg_stop2_i;
                    end
                end
                ST_STOP2: begin
                    done          = 1'b1;
                    err_set.frame = !vote;
                end
                default: ;
            endcase
        end
        err_set.parity  = done && cfg_parity_en_i && (par_bit != par_exp);
        err_set.overrun = done && !accept;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            bit_idx    <= '0;
            data_sr    <= '0;
            par_bit    <= 1'b0;
            samp_e     <= 1'b1;
            samp_m     <= 1'b1;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            err_q      <= '0;
        end else begin
            if (bit_end || start_det) begin
                samp_e <= 1'b1;
                samp_m <= 1'b1;
            end else begin
                if (smp_early) samp_e <= rx_s;
                if (smp_mid)   samp_m <= rx_s;
            end

            if (!cfg_en_i) begin
                state_q <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE:  if (start_det) state_q <= ST_START;
                    ST_START: if (smp_late) begin
                        state_q <= vote ? ST_IDLE : ST_DATA;
                        bit_idx <= '0;
                        data_sr <= '0;
                        par_bit <= 1'b0;
                    end
                    ST_DATA: if (smp_late) begin
                        data_sr <= {vote, data_sr[MAX_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 4'd1;
                        if (last_bit) state_q <= cfg_parity_en_i ? ST_PARITY : ST_STOP1;
                    end
                    ST_PARITY: if (smp_late) begin
                        par_bit <= vote;
                        state_q <= ST_STOP1;
                    end
                    ST_STOP1: if (smp_late) begin
                        if (vote)          state_q <= cfg_stop2_i ? ST_STOP2 : ST_IDLE;
                        else if (is_break) state_q <= ST_BREAK_WAIT;
                        else               state_q <= ST_IDLE;
                    end
                    ST_STOP2:      if (smp_late) state_q <= ST_IDLE;
                    ST_BREAK_WAIT: if (rx_s)     state_q <= ST_IDLE;
                    default:                     state_q <= ST_IDLE;
                endcase
            end

            if (!cfg_en_i) begin
                rx_valid_o <= 1'b0;
            end else if (done && accept) begin
                rx_data_o  <= data_sr >> shamt;
                rx_valid_o <= 1'b1;
            end else if (rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            if (err_clr_i) err_q <= '0;
            else           err_q <= err_q | err_set;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign parity_err_o = err_q.parity;
    assign frame_err_o  = err_q.frame;
    assign overrun_o    = err_q.overrun;
    assign break_o      = err_q.brk;

endmodule
